// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-port memory controller sitting between the multicycle
// datapath and a ready/valid memory bus. Owns IR, old-PC and load-data (DR)
// registers, formats store strobes/data and load data, and stalls the control
// FSM while a bus transaction is outstanding.
//
// state | meaning
// IDLE  | waiting for irwrite/memwrite/memread; stall follows the request lines
// REQ   | bus_req_valid high, address/we/strobe/data held until bus_req_ready
// RESP  | fetch/load accepted, waiting for bus_rsp_valid
// DONE  | one unstalled cycle; error pulses are visible here
module mem_port_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [31:0]       pc,
    input  logic [31:0]       wdata,
    input  logic [2:0]        funct3,
    input  logic              irwrite,
    input  logic              memwrite,
    input  logic              memread,
    output logic              stall,
    output logic [31:0]       instr,
    output logic [31:0]       oldpc,
    output logic [31:0]       rdata_q,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              proto_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata
);

    // Watchdog is a down-counter loaded with TIMEOUT-1 so that the abort lands
    // after exactly TIMEOUT cycles spent in REQ or RESP.
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    typedef enum logic [1:0] {K_FETCH, K_STORE, K_LOAD} kind_t;

    state_t          state;
    kind_t           kind_q;
    kind_t           kind_new;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic [31:0]     pc_q;
    logic [WD_W-1:0] wd_cnt;

    logic        any_req;
    logic        multi_req;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        wd_expired;
    logic [3:0]  strb_new;
    logic [31:0] wdata_new;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign any_req    = irwrite | memwrite | memread;
    assign multi_req  = (irwrite & memwrite) | (irwrite & memread) | (memwrite & memread);
    assign is_byte    = (funct3 == 3'b000) || (funct3 == 3'b100);
    assign is_half    = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == '0);
    assign stall      = ((state == IDLE) && any_req) || (state == REQ) || (state == RESP);

    // Decode the incoming request: winner by priority, alignment, store lanes.
    always_comb begin
        kind_new   = K_LOAD;
        misaligned = 1'b0;
        strb_new   = 4'b0000;
        wdata_new  = wdata;
        if (irwrite) begin
            kind_new   = K_FETCH;
            misaligned = (adr[1:0] != 2'b00);
        end else begin
            if (memwrite) kind_new = K_STORE;
            if (is_byte)      misaligned = 1'b0;
            else if (is_half) misaligned = adr[0];
            else              misaligned = (adr[1:0] != 2'b00);
            if (memwrite) begin
                if (is_byte) begin
                    strb_new  = 4'b0001 << adr[1:0];
                    wdata_new = {4{wdata[7:0]}};
                end else if (is_half) begin
                    strb_new  = 4'b0011 << adr[1:0];
                    wdata_new = {2{wdata[15:0]}};
                end else begin
                    strb_new  = 4'b1111;
                end
            end
        end
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        load_byte = bus_rdata[{off_q, 3'b000} +: 8];
        load_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0, load_half};
            default: load_data = bus_rdata;
        endcase
    end

    // Transaction FSM with registered bus outputs, capture registers and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            kind_q        <= K_FETCH;
            off_q         <= 2'b00;
            f3_q          <= 3'b000;
            pc_q          <= '0;
            wd_cnt        <= '0;
            instr         <= '0;
            oldpc         <= '0;
            rdata_q       <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
            proto_err     <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_addr      <= '0;
            bus_we        <= 1'b0;
            bus_wstrb     <= 4'b0000;
            bus_wdata     <= '0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        kind_q    <= kind_new;
                        off_q     <= adr[1:0];
                        f3_q      <= funct3;
                        pc_q      <= pc;
                        bus_addr  <= {adr[ADDR_W-1:2], 2'b00};
                        bus_we    <= (kind_new == K_STORE);
                        bus_wstrb <= strb_new;
                        bus_wdata <= wdata_new;
                        if (multi_req) proto_err <= 1'b1;
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bus_req_valid <= 1'b1;
                            wd_cnt        <= WD_LOAD;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        if (kind_q == K_STORE) begin
                            state <= DONE;
                        end else if (bus_rsp_valid) begin
                            if (kind_q == K_FETCH) begin
                                instr <= bus_rdata;
                                oldpc <= pc_q;
                            end else begin
                                rdata_q <= load_data;
                            end
                            state <= DONE;
                        end else begin
                            wd_cnt <= WD_LOAD;
                            state  <= RESP;
                        end
                    end else if (wd_expired) begin
                        bus_req_valid <= 1'b0;
                        bus_err       <= 1'b1;
                        state         <= DONE;
                    end else if (wd_cnt != '0) begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
                end
                RESP: begin
                    if (bus_rsp_valid) begin
                        if (kind_q == K_FETCH) begin
                            instr <= bus_rdata;
                            oldpc <= pc_q;
                        end else begin
                            rdata_q <= load_data;
                        end
                        state <= DONE;
                    end else if (wd_expired) begin
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else if (wd_cnt != '0) begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: directed scenarios followed by randomized
// transactions, each checked against a size/offset arithmetic model.
module tb_mem_port_ctrl;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       pc;
    logic [31:0]       wdata;
    logic [2:0]        funct3;
    logic              irwrite;
    logic              memwrite;
    logic              memread;
    logic              stall;
    logic [31:0]       instr;
    logic [31:0]       oldpc;
    logic [31:0]       rdata_q;
    logic              misalign_err;
    logic              bus_err;
    logic              proto_err;
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic              bus_rsp_valid;
    logic [31:0]       bus_rdata;

    mem_port_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .adr(adr), .pc(pc), .wdata(wdata), .funct3(funct3),
        .irwrite(irwrite), .memwrite(memwrite), .memread(memread), .stall(stall),
        .instr(instr), .oldpc(oldpc), .rdata_q(rdata_q), .misalign_err(misalign_err),
        .bus_err(bus_err), .proto_err(proto_err), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_instr;
    logic [31:0] exp_oldpc;
    logic [31:0] exp_rdq;
    logic        exp_proto;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int sz;
        int off;
        logic [31:0] mask;
        logic [31:0] v;
        sz  = size_of(f3);
        off = int'(a[1:0]);
        if (sz == 4) return rd;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v    = (rd >> (8 * off)) & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] strb_model(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_of(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One request issued from IDLE; the bench plays the bus with the given
    // ready / response delays and checks the whole transaction.
    task automatic run_txn(input logic fi, input logic st, input logic ld,
                           input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] wd, input logic [31:0] p, input logic [31:0] rd,
                           input int rdy_dly, input int rsp_dly, input logic no_ready,
                           input string tag);
        logic is_store;
        logic mis;
        logic timeout_exp;
        logic valid_seen;
        logic done;
        int   exp_stall;
        int   n_stall;
        int   req_wait;
        int   resp_wait;
        is_store    = !fi && st;
        mis         = fi ? (a[1:0] != 2'b00) : ((a % size_of(f3)) != 0);
        timeout_exp = no_ready && !mis;
        if (mis)           exp_stall = 1;
        else if (no_ready) exp_stall = 1 + TIMEOUT;
        else if (is_store) exp_stall = 2 + rdy_dly;
        else               exp_stall = 2 + rdy_dly + rsp_dly;
        if ((int'(fi) + int'(st) + int'(ld)) > 1) exp_proto = 1'b1;
        valid_seen = 1'b0;
        done       = 1'b0;
        n_stall    = 1;
        req_wait   = 0;
        resp_wait  = 0;

        @(negedge clk);
        adr = a; funct3 = f3; wdata = wd; pc = p;
        irwrite = fi; memwrite = st; memread = ld;
        #1 check({tag, ".stall_c0"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        irwrite = 1'b0; memwrite = 1'b0; memread = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (!stall) begin
                done = 1'b1;
            end else begin
                n_stall++;
                if (bus_req_valid) begin
                    valid_seen = 1'b1;
                    check({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
                    check({tag, ".bus_we"}, 32'(bus_we), 32'(is_store));
                    if (is_store) begin
                        check({tag, ".bus_wstrb"}, 32'(bus_wstrb), 32'(strb_model(f3, a)));
                        check({tag, ".bus_wdata"}, bus_wdata, wdata_model(f3, wd));
                    end
                    if (!no_ready && req_wait == rdy_dly) begin
                        bus_req_ready = 1'b1;
                        if (!is_store && rsp_dly == 0) begin
                            bus_rsp_valid = 1'b1;
                            bus_rdata     = rd;
                        end
                    end else begin
                        req_wait++;
                    end
                end else begin
                    if (resp_wait + 1 == rsp_dly) begin
                        bus_rsp_valid = 1'b1;
                        bus_rdata     = rd;
                    end else begin
                        resp_wait++;
                    end
                end
                @(posedge clk);
                #1;
                bus_req_ready = 1'b0;
                bus_rsp_valid = 1'b0;
                bus_rdata     = $urandom;
            end
        end
        check({tag, ".finished_in_budget"}, 32'(done), 32'd1);
        check({tag, ".stall_cycles"}, 32'(n_stall), 32'(exp_stall));
        check({tag, ".misalign_err"}, 32'(misalign_err), 32'(mis));
        check({tag, ".bus_err"}, 32'(bus_err), 32'(timeout_exp));
        check({tag, ".req_valid_done"}, 32'(bus_req_valid), 32'd0);
        check({tag, ".req_issued"}, 32'(valid_seen), 32'(!mis));
        check({tag, ".proto_err"}, 32'(proto_err), 32'(exp_proto));
        if (!mis && !no_ready && !is_store) begin
            if (fi) begin
                exp_instr = rd;
                exp_oldpc = p;
            end else begin
                exp_rdq = load_model(f3, a, rd);
            end
        end
        check({tag, ".instr"}, instr, exp_instr);
        check({tag, ".oldpc"}, oldpc, exp_oldpc);
        check({tag, ".rdata_q"}, rdata_q, exp_rdq);
        @(posedge clk);
        #1;
        check({tag, ".err_pulse_end"}, {30'h0, misalign_err, bus_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int          k;
        logic        fi;
        logic        st;
        logic        ld;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [2:0]  ld_f3 [6];
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

        reset = 1'b1;
        adr = '0; pc = '0; wdata = '0; funct3 = '0;
        irwrite = 1'b0; memwrite = 1'b0; memread = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
        exp_instr = '0; exp_oldpc = '0; exp_rdq = '0; exp_proto = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.instr", instr, 32'd0);
        check("reset.oldpc", oldpc, 32'd0);
        check("reset.rdata_q", rdata_q, 32'd0);
        check("reset.flags", {28'h0, misalign_err, bus_err, proto_err, bus_req_valid}, 32'd0);

        run_txn(1, 0, 0, 32'h10, 3'b010, 32'h0, 32'h10, 32'h0052_8293, 0, 1, 0, "fetch");
        check("fetch.instr_lit", instr, 32'h0052_8293);
        run_txn(0, 1, 0, 32'h103, 3'b000, 32'hAB, 32'h0, 32'h0, 0, 0, 0, "sb");
        run_txn(0, 0, 1, 32'h202, 3'b000, 32'h0, 32'h0, 32'h1280_3456, 1, 0, 0, "lb");
        check("lb.lit", rdata_q, 32'hFFFF_FF80);
        run_txn(0, 0, 1, 32'h202, 3'b100, 32'h0, 32'h0, 32'h1280_3456, 0, 2, 0, "lbu");
        check("lbu.lit", rdata_q, 32'h0000_0080);
        run_txn(0, 0, 1, 32'h202, 3'b001, 32'h0, 32'h0, 32'h1280_3456, 2, 1, 0, "lh");
        check("lh.lit", rdata_q, 32'h0000_1280);
        run_txn(0, 0, 1, 32'h006, 3'b010, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 0, 0, "lw_misalign");
        run_txn(0, 1, 0, 32'h301, 3'b001, 32'h1234, 32'h0, 32'h0, 0, 0, 0, "sh_misalign");
        run_txn(0, 0, 1, 32'h400, 3'b010, 32'h0, 32'h0, 32'h5555_AAAA, 0, 0, 1, "timeout");
        run_txn(1, 1, 0, 32'h20, 3'b010, 32'h0, 32'h20, 32'h0000_0013, 0, 0, 0, "multi");
        run_txn(0, 1, 0, 32'h40, 3'b010, 32'h9876_5432, 32'h0, 32'h0, 1, 0, 0, "sw_after_multi");

        // Reset while waiting in RESP; a late response must be ignored.
        @(negedge clk);
        adr = 32'h80; funct3 = 3'b010; pc = 32'h80; irwrite = 1'b1;
        @(posedge clk);
        #1 irwrite = 1'b0; bus_req_ready = 1'b1;
        @(posedge clk);
        #1 bus_req_ready = 1'b0;
        check("rst_resp.stall_resp", 32'(stall), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_instr = '0; exp_oldpc = '0; exp_rdq = '0; exp_proto = 1'b0;
        check("rst_resp.stall_idle", 32'(stall), 32'd0);
        check("rst_resp.proto_cleared", 32'(proto_err), 32'd0);
        bus_rsp_valid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus_rsp_valid = 1'b0;
        check("rst_resp.instr", instr, exp_instr);
        check("rst_resp.oldpc", oldpc, exp_oldpc);
        check("rst_resp.stall_after", 32'(stall), 32'd0);
        check("rst_resp.req_valid", 32'(bus_req_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            k  = int'($urandom_range(0, 9));
            fi = 1'b0; st = 1'b0; ld = 1'b0;
            if (k <= 2)      fi = 1'b1;
            else if (k <= 5) st = 1'b1;
            else if (k <= 8) ld = 1'b1;
            else begin
                fi = 1'($urandom_range(0, 1));
                st = 1'b1;
                ld = 1'b1;
            end
            a = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
            if (st && !fi) f3 = 3'($urandom_range(0, 2));
            else           f3 = ld_f3[$urandom_range(0, 5)];
            run_txn(fi, st, ld, a, f3, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Single-port memory controller between the multicycle datapath (driven by the main control FSM's irwrite/memwrite/adrsrc outputs) and an external ready/valid memory bus.
- Owns the instruction register (IR), the old-PC register and the load-data register (DR).
- Formats store byte strobes and load data.
- Raises stall so the control FSM and datapath hold state while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, max cycles waiting in REQ or RESP before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- adr  in  ADDR_W  byte address from the datapath address mux.
- pc  in  32  current PC; captured into oldpc on fetch.
- wdata  in  32  store data (rs2 value, unshifted).
- funct3  in  3  load/store size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- irwrite  in  1  fetch request.
- memwrite  in  1  store request.
- memread  in  1  load request.
- stall  out  1  hold FSM state and gate pcupdate/regwrite while high.
- instr  out  32  instruction register.
- oldpc  out  32  PC of the instruction in instr.
- rdata_q  out  32  formatted load data register.
- misalign_err  out  1  one-cycle pulse on a misaligned request.
- bus_err  out  1  one-cycle pulse on watchdog abort.
- proto_err  out  1  sticky; more than one request asserted together.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_addr  out  ADDR_W  word-aligned address (adr with [1:0] forced to 0).
- bus_we  out  1  write request.
- bus_wstrb  out  4  byte strobes.
- bus_wdata  out  32  lane-shifted store data.
- bus_rsp_valid  in  1  read data valid.
- bus_rdata  in  32  read data word.

Behaviour:
- Reset (synchronous, active-high) values: state IDLE; stall 0; all registers and pulse outputs 0; proto_err 0; bus_req_valid 0.
- Reset mid-transaction: go to IDLE next edge. Any bus_rsp_valid arriving later in IDLE is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE, no request: stall = 0.
- IDLE, request present:
  - Stall is asserted combinationally in the same cycle.
  - Priority irwrite > memwrite > memread.
  - If more than one request is high, set proto_err (cleared only by reset).
  - Latch kind, adr, funct3, wdata and pc.
  - Misaligned request: fetch with adr[1:0] != 0; h/hu with adr[0] = 1; w with adr[1:0] != 0. Issue no bus request, go to DONE, pulse misalign_err in DONE, leave IR/DR unchanged.
  - Otherwise go to REQ.
- REQ:
  - bus_req_valid = 1; address, we, strobe and data are held stable until accepted.
  - On bus_req_ready: a store goes to DONE; a fetch or load goes to RESP.
  - bus_rsp_valid in the same cycle as ready is legal; capture it and go straight to DONE.
- RESP:
  - On bus_rsp_valid: fetch loads instr <= bus_rdata and oldpc <= latched pc; load loads rdata_q <= extracted data. Then go to DONE.
- DONE:
  - stall = 0 for exactly one cycle, then return to IDLE.
  - Requests seen in DONE are ignored. The FSM has advanced by the next cycle, so back-to-back requests cost one idle cycle.
- Watchdog:
  - The counter clears on entry to REQ and on entry to RESP.
  - If it reaches TIMEOUT in REQ or RESP: drop bus_req_valid, go to DONE, pulse bus_err, leave IR/DR unchanged.
- Store formatting, with off = adr[1:0]:
  - sb: wstrb = 0001 << off; wdata byte replicated to all 4 lanes.
  - sh: wstrb = 0011 << off; halfword replicated to both halves.
  - sw: wstrb = 1111.
- Load extraction: select the byte or half at off, then sign-extend (b, h) or zero-extend (bu, hu); w passes through.
- An unlisted funct3 on load or store is treated as w.
- Latency with zero-wait bus (ready and rsp_valid in the same cycle): request in IDLE at cycle 0, REQ at cycle 1, DONE at cycle 2, so stall is high for cycles 0–1.

Test Plan:
- Fetch, adr=0x0000_0010, pc=0x10, bus ready at once, rdata=0x0052_8293 one cycle later -> instr=0x0052_8293, oldpc=0x10, stall high exactly 3 cycles, then one low cycle.
- sb, adr=0x103, wdata=0x0000_00AB -> bus_wstrb=1000, bus_wdata=0xABAB_ABAB, bus_addr=0x100, bus_we=1, no RESP state.
- lb, adr=0x202, bus_rdata=0x1280_3456 -> rdata_q=0xFFFF_FF80; lbu at the same address -> 0x0000_0080; lh at adr=0x202 -> 0x0000_1280.
- lw, adr=0x006 -> no bus_req_valid ever, misalign_err pulses one cycle, rdata_q unchanged.
- TIMEOUT=4, bus_req_ready held 0 -> after 4 REQ cycles bus_req_valid drops, bus_err pulses, FSM released.
- Reset asserted in RESP, then bus_rsp_valid arrives -> state IDLE, instr unchanged; separately, irwrite and memwrite together -> fetch performed and proto_err stays 1 until reset.
